pipe_control: RTL and testbench

Pipelined successor to the single-cycle opcode decoder for the 4-bit-opcode core. It decodes the instruction in ID and carries the control bundle through EX, MEM and WB stage registers. It also detects load-use hazards, holds the pipe for multi-cycle memory accesses, and resolves BEZ/BNZ in EX with a flush of the younger instruction. It sits between the fetch/ID latch and the datapath; all datapath muxes take their selects from the stage-matched outputs.

---
 rtl/pipe_control.sv | 170 +++++++++++++++++
 tb/tb_pipe_control.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipelined control for the 4-bit-opcode core: ID decode, EX/MEM/WB control
// stage registers, load-use stall, multi-cycle memory hold and EX branch flush.
module pipe_control #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUOPW  = 5,
  parameter int unsigned RAW     = 4,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPW-1:0]    id_opcode,
  input  logic [RAW-1:0]    id_rs,
  input  logic [RAW-1:0]    id_rt,
  input  logic [RAW-1:0]    id_rd,
  input  logic              ex_zero,
  output logic              id_ready,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic [ALUOPW-1:0] ex_aluop,
  output logic              ex_regdst,
  output logic              mem_valid,
  output logic              mem_memwrite,
  output logic              mem_memsrc,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [RAW-1:0]    wb_dst,
  output logic              br_taken,
  output logic              illegal
);

  localparam int unsigned    CNTW      = 4;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MEM_LAT - 1);

  // Control bundle carried from ID into EX; later stages keep only what they use.
  typedef struct packed {
    logic              alusrc;
    logic [ALUOPW-1:0] aluop;
    logic              regdst;
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              memsrc;
    logic              bez;
    logic              bnz;
    logic              lw;
    logic              memop;
    logic [RAW-1:0]    dst;
  } ctrl_t;

  ctrl_t           dec;
  logic            dec_illegal;
  logic            reads_rs;
  logic            reads_rt;
  logic            op_hi_zero;
  logic [3:0]      op_lo;

  ctrl_t           ex_c;
  logic            mem_regwrite;
  logic            mem_memtoreg;
  logic            mem_memop;
  logic [RAW-1:0]  mem_dst;
  logic [CNTW-1:0] hold_cnt;

  logic            mem_hold;
  logic            src_hit;
  logic            load_use;
  logic            accept;

  assign op_hi_zero = ((id_opcode >> 4) == '0);
  assign op_lo      = id_opcode[3:0];

  // Opcode decode; anything undefined yields the NOP bundle and flags illegal.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    if (op_hi_zero) begin
      unique case (op_lo)
        4'h0: ;
        4'h1: begin dec.aluop = ALUOPW'(2);  dec.regdst = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'h2: begin dec.aluop = ALUOPW'(2);  dec.alusrc = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; end
        4'h3: begin dec.aluop = ALUOPW'(14); dec.regdst = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'h4: begin dec.aluop = ALUOPW'(0);  dec.regdst = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'h5: begin dec.aluop = ALUOPW'(1);  dec.regdst = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'h6: begin dec.aluop = ALUOPW'(15); dec.regdst = 1'b1; dec.regwrite = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'h8: begin
          dec.regdst = 1'b1; dec.regwrite = 1'b1; dec.memtoreg = 1'b1;
          dec.lw = 1'b1; dec.memop = 1'b1; reads_rs = 1'b1;
        end
        4'h9: begin dec.memwrite = 1'b1; dec.memop = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
        4'hA: begin dec.memwrite = 1'b1; dec.memsrc = 1'b1; dec.memop = 1'b1; reads_rs = 1'b1; end
        4'hC: begin dec.bez = 1'b1; reads_rs = 1'b1; end
        4'hD: begin dec.bnz = 1'b1; reads_rs = 1'b1; end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_illegal = 1'b1;
    end
    dec.dst = dec.regdst ? id_rd : id_rt;
  end

  // Hazard resolution: memory hold outranks branch flush, which outranks load-use.
  always_comb begin
    mem_hold = mem_valid & mem_memop & (hold_cnt < HOLD_LAST);
    br_taken = ex_valid & ((ex_c.bez & ex_zero) | (ex_c.bnz & ~ex_zero)) & ~mem_hold;
    src_hit  = (reads_rs & (id_rs == ex_c.dst)) | (reads_rt & (id_rt == ex_c.dst));
    load_use = ex_valid & ex_c.lw & id_valid & src_hit & ~mem_hold & ~br_taken;
    id_ready = ~mem_hold & ~load_use;
    accept   = id_valid & id_ready;
  end

  // Stage registers: freeze ID/EX/MEM while MEM is held, bubble into WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_c         <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memsrc   <= 1'b0;
      mem_memop    <= 1'b0;
      mem_dst      <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_dst       <= '0;
      hold_cnt     <= '0;
      illegal      <= 1'b0;
    end else begin
      illegal <= accept & dec_illegal;
      if (mem_hold) begin
        hold_cnt    <= hold_cnt + CNTW'(1);
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
        wb_memtoreg <= 1'b0;
        wb_dst      <= '0;
      end else begin
        hold_cnt    <= '0;
        wb_valid    <= mem_valid;
        wb_regwrite <= mem_regwrite;
        wb_memtoreg <= mem_memtoreg;
        wb_dst      <= mem_dst;
        // A taken branch moves on as an empty bundle.
        mem_valid    <= ex_valid;
        mem_regwrite <= ex_c.regwrite & ~br_taken;
        mem_memtoreg <= ex_c.memtoreg & ~br_taken;
        mem_memwrite <= ex_c.memwrite & ~br_taken;
        mem_memsrc   <= ex_c.memsrc & ~br_taken;
        mem_memop    <= ex_c.memop & ~br_taken;
        mem_dst      <= br_taken ? '0 : ex_c.dst;
        if (accept && !br_taken) begin
          ex_valid <= 1'b1;
          ex_c     <= dec;
        end else begin
          ex_valid <= 1'b0;
          ex_c     <= '0;
        end
      end
    end
  end

  assign ex_alusrc = ex_c.alusrc;
  assign ex_aluop  = ex_c.aluop;
  assign ex_regdst = ex_c.regdst;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboarded bench for pipe_control; three instances cover MEM_LAT = 1, 3, 4.
module tb_pipe_control;

  localparam int unsigned NDUT = 3;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_ADDI = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_OR = 4'h5, OP_SLT = 4'h6, OP_LW = 4'h8,
                         OP_SW = 4'h9, OP_SWI = 4'hA, OP_BEZ = 4'hC, OP_BNZ = 4'hD;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic [3:0] id_rd;
  logic       ex_zero;

  logic       id_ready     [NDUT];
  logic       ex_valid     [NDUT];
  logic       ex_alusrc    [NDUT];
  logic [4:0] ex_aluop     [NDUT];
  logic       ex_regdst    [NDUT];
  logic       mem_valid    [NDUT];
  logic       mem_memwrite [NDUT];
  logic       mem_memsrc   [NDUT];
  logic       wb_valid     [NDUT];
  logic       wb_regwrite  [NDUT];
  logic       wb_memtoreg  [NDUT];
  logic [3:0] wb_dst       [NDUT];
  logic       br_taken     [NDUT];
  logic       illegal      [NDUT];

  int         checks;
  int         failures;
  int         sel;
  logic [3:0] exp_q[$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    pipe_control #(.OPW(4), .ALUOPW(5), .RAW(4), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .id_ready(id_ready[g]), .ex_valid(ex_valid[g]), .ex_alusrc(ex_alusrc[g]),
      .ex_aluop(ex_aluop[g]), .ex_regdst(ex_regdst[g]), .mem_valid(mem_valid[g]),
      .mem_memwrite(mem_memwrite[g]), .mem_memsrc(mem_memsrc[g]), .wb_valid(wb_valid[g]),
      .wb_regwrite(wb_regwrite[g]), .wb_memtoreg(wb_memtoreg[g]), .wb_dst(wb_dst[g]),
      .br_taken(br_taken[g]), .illegal(illegal[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every register write leaving WB must match the oldest expected dest.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid[sel] && wb_regwrite[sel]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected dut%0d got dst=%0d required no write", sel, wb_dst[sel]);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (wb_dst[sel] !== e) begin
            failures++;
            $display("FAIL wb_dst dut%0d got %0d required %0d", sel, wb_dst[sel], e);
          end
        end
      end
      for (int g = 0; g < NDUT; g++) begin
        checks++;
        if ((mem_memwrite[g] && !mem_valid[g]) || (wb_regwrite[g] && !wb_valid[g])) begin
          failures++;
          $display("FAIL strobe_on_bubble dut%0d mw=%0b mv=%0b rw=%0b wv=%0b required no strobe",
                   g, mem_memwrite[g], mem_valid[g], wb_regwrite[g], wb_valid[g]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    #12;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({ex_valid[g], mem_valid[g], wb_valid[g], illegal[g], br_taken[g], id_ready[g],
           mem_memwrite[g], wb_regwrite[g], wb_dst[g]} !== 12'b00000100_0000) begin
        failures++;
        $display("FAIL reset_state dut%0d got ev=%0b mv=%0b wv=%0b ill=%0b br=%0b rdy=%0b required 0,0,0,0,0,1",
                 g, ex_valid[g], mem_valid[g], wb_valid[g], illegal[g], br_taken[g], id_ready[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    sel = 0;
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd1);
    exp_q.push_back(4'd1);
    checks++;
    if (id_ready[0] !== 1'b1) begin failures++; $display("FAIL alu_ready0 got %0b required 1", id_ready[0]); end
    tick();
    drive(1'b1, OP_ADDI, 4'd1, 4'd4, 4'd0);
    exp_q.push_back(4'd4);
    checks++;
    if ({ex_valid[0], ex_aluop[0], ex_alusrc[0], ex_regdst[0], id_ready[0], illegal[0]} !== 10'b1_00010_0_1_1_0) begin
      failures++;
      $display("FAIL alu_ex_add got v=%0b op=%b src=%0b dst=%0b rdy=%0b ill=%0b required 1 00010 0 1 1 0",
               ex_valid[0], ex_aluop[0], ex_alusrc[0], ex_regdst[0], id_ready[0], illegal[0]);
    end
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({ex_valid[0], ex_aluop[0], ex_alusrc[0], ex_regdst[0]} !== 8'b1_00010_1_0) begin
      failures++;
      $display("FAIL alu_ex_addi got v=%0b op=%b src=%0b dst=%0b required 1 00010 1 0",
               ex_valid[0], ex_aluop[0], ex_alusrc[0], ex_regdst[0]);
    end
    tick();
    checks++;
    if ({wb_valid[0], wb_regwrite[0], wb_memtoreg[0], wb_dst[0]} !== {3'b110, 4'd1}) begin
      failures++;
      $display("FAIL alu_wb_add got v=%0b rw=%0b m2r=%0b dst=%0d required 1 1 0 1",
               wb_valid[0], wb_regwrite[0], wb_memtoreg[0], wb_dst[0]);
    end
    tick();
    checks++;
    if ({wb_valid[0], wb_regwrite[0], wb_dst[0]} !== {2'b11, 4'd4}) begin
      failures++;
      $display("FAIL alu_wb_addi got v=%0b rw=%0b dst=%0d required 1 1 4", wb_valid[0], wb_regwrite[0], wb_dst[0]);
    end
    drain(4);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL alu_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_decode();
    logic [3:0] ops [5];
    logic [4:0] alu [5];
    logic       rdst;
    sel = 0;
    ops = '{OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOP};
    alu = '{5'b01110, 5'b00000, 5'b00001, 5'b01111, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], 4'(i), 4'(i + 1), 4'(i + 8));
      if (ops[i] != OP_NOP) exp_q.push_back(4'(i + 8));
      tick();
      rdst = (ops[i] != OP_NOP);
      checks++;
      if ({ex_valid[0], ex_aluop[0], ex_regdst[0], ex_alusrc[0]} !== {1'b1, alu[i], rdst, 1'b0}) begin
        failures++;
        $display("FAIL decode_op%0h got v=%0b op=%b dst=%0b src=%0b required 1 %b %0b 0",
                 ops[i], ex_valid[0], ex_aluop[0], ex_regdst[0], ex_alusrc[0], alu[i], rdst);
      end
    end
    drive(1'b1, OP_SWI, 4'd1, 4'd0, 4'd0);
    tick();
    drive(1'b1, OP_SW, 4'd1, 4'd2, 4'd0);
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({mem_valid[0], mem_memwrite[0], mem_memsrc[0]} !== 3'b111) begin
      failures++;
      $display("FAIL decode_swi got v=%0b mw=%0b ms=%0b required 1 1 1", mem_valid[0], mem_memwrite[0], mem_memsrc[0]);
    end
    tick();
    checks++;
    if ({mem_valid[0], mem_memwrite[0], mem_memsrc[0]} !== 3'b110) begin
      failures++;
      $display("FAIL decode_sw got v=%0b mw=%0b ms=%0b required 1 1 0", mem_valid[0], mem_memwrite[0], mem_memsrc[0]);
    end
    drain(4);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL decode_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_load_use();
    sel = 0;
    drive(1'b1, OP_LW, 4'd7, 4'd0, 4'd5);
    exp_q.push_back(4'd5);
    tick();
    drive(1'b1, OP_ADD, 4'd5, 4'd0, 4'd6);
    exp_q.push_back(4'd6);
    checks++;
    if ({id_ready[0], ex_valid[0]} !== 2'b01) begin
      failures++;
      $display("FAIL lu_stall got rdy=%0b ev=%0b required 0 1", id_ready[0], ex_valid[0]);
    end
    tick();
    drive(1'b1, OP_ADD, 4'd5, 4'd0, 4'd6);
    checks++;
    if ({id_ready[0], ex_valid[0]} !== 2'b10) begin
      failures++;
      $display("FAIL lu_bubble got rdy=%0b ev=%0b required 1 0", id_ready[0], ex_valid[0]);
    end
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({ex_valid[0], ex_aluop[0], wb_valid[0], wb_memtoreg[0], wb_dst[0]} !== {1'b1, 5'b00010, 2'b11, 4'd5}) begin
      failures++;
      $display("FAIL lu_lw_wb got ev=%0b op=%b wv=%0b m2r=%0b dst=%0d required 1 00010 1 1 5",
               ex_valid[0], ex_aluop[0], wb_valid[0], wb_memtoreg[0], wb_dst[0]);
    end
    tick();
    tick();
    checks++;
    if ({wb_valid[0], wb_regwrite[0], wb_memtoreg[0], wb_dst[0]} !== {3'b110, 4'd6}) begin
      failures++;
      $display("FAIL lu_add_wb got v=%0b rw=%0b m2r=%0b dst=%0d required 1 1 0 6",
               wb_valid[0], wb_regwrite[0], wb_memtoreg[0], wb_dst[0]);
    end
    drive(1'b1, OP_LW, 4'd7, 4'd0, 4'd5);
    exp_q.push_back(4'd5);
    tick();
    drive(1'b1, OP_ADD, 4'd1, 4'd2, 4'd6);
    exp_q.push_back(4'd6);
    checks++;
    if (id_ready[0] !== 1'b1) begin failures++; $display("FAIL lu_nohazard got rdy=%0b required 1", id_ready[0]); end
    tick();
    drain(5);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL lu_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_mem_hold();
    logic [3:0] mw_h, rdy_h, wbv_h;
    sel = 1;
    mw_h = '0; rdy_h = '0; wbv_h = '0;
    drive(1'b1, OP_SW, 4'd1, 4'd2, 4'd0);
    tick();
    drive(1'b1, OP_ADD, 4'd3, 4'd4, 4'd8);
    exp_q.push_back(4'd8);
    checks++;
    if (id_ready[1] !== 1'b1) begin failures++; $display("FAIL hold_accept got rdy=%0b required 1", id_ready[1]); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
      mw_h  = {mw_h[2:0], mem_memwrite[1]};
      rdy_h = {rdy_h[2:0], id_ready[1]};
      wbv_h = {wbv_h[2:0], wb_valid[1]};
      if (k == 2) begin
        checks++;
        if (ex_valid[1] !== 1'b1) begin failures++; $display("FAIL hold_ex_frozen got ev=%0b required 1", ex_valid[1]); end
      end
      tick();
    end
    checks++;
    if ({mw_h, rdy_h, wbv_h} !== {4'b1110, 4'b0011, 4'b0001}) begin
      failures++;
      $display("FAIL hold_pattern got mw=%b rdy=%b wbv=%b required 1110 0011 0001", mw_h, rdy_h, wbv_h);
    end
    drain(4);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL hold_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_branch();
    int rw_cnt;
    sel = 0;
    drive(1'b1, OP_BEZ, 4'd1, 4'd0, 4'd0);
    tick();
    ex_zero = 1'b1;
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd9);
    checks++;
    if ({br_taken[0], id_ready[0]} !== 2'b11) begin
      failures++;
      $display("FAIL bez_taken got br=%0b rdy=%0b required 1 1", br_taken[0], id_ready[0]);
    end
    tick();
    ex_zero = 1'b0;
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({br_taken[0], ex_valid[0], mem_valid[0], mem_memwrite[0]} !== 4'b0010) begin
      failures++;
      $display("FAIL bez_flush got br=%0b ev=%0b mv=%0b mw=%0b required 0 0 1 0",
               br_taken[0], ex_valid[0], mem_valid[0], mem_memwrite[0]);
    end
    rw_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wb_regwrite[0]) rw_cnt++;
    end
    checks++;
    if (rw_cnt != 0) begin failures++; $display("FAIL bez_no_wb got writes=%0d required 0", rw_cnt); end
    drive(1'b1, OP_BEZ, 4'd1, 4'd0, 4'd0);
    tick();
    ex_zero = 1'b0;
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd9);
    exp_q.push_back(4'd9);
    checks++;
    if ({br_taken[0], id_ready[0]} !== 2'b01) begin
      failures++;
      $display("FAIL bez_not_taken got br=%0b rdy=%0b required 0 1", br_taken[0], id_ready[0]);
    end
    tick();
    drive(1'b1, OP_BNZ, 4'd1, 4'd0, 4'd0);
    checks++;
    if ({ex_valid[0], ex_aluop[0]} !== 6'b1_00010) begin
      failures++;
      $display("FAIL bez_add_ex got ev=%0b op=%b required 1 00010", ex_valid[0], ex_aluop[0]);
    end
    tick();
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd12);
    checks++;
    if (br_taken[0] !== 1'b1) begin failures++; $display("FAIL bnz_taken got br=%0b required 1", br_taken[0]); end
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if (ex_valid[0] !== 1'b0) begin failures++; $display("FAIL bnz_flush got ev=%0b required 0", ex_valid[0]); end
    drain(5);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL br_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_illegal();
    int strobes;
    sel = 0;
    drive(1'b1, 4'hF, 4'd1, 4'd2, 4'd3);
    checks++;
    if ({id_ready[0], illegal[0]} !== 2'b10) begin
      failures++;
      $display("FAIL ill_accept got rdy=%0b ill=%0b required 1 0", id_ready[0], illegal[0]);
    end
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    checks++;
    if ({illegal[0], ex_valid[0], ex_aluop[0], ex_regdst[0], ex_alusrc[0]} !== 9'b11_00000_00) begin
      failures++;
      $display("FAIL ill_pulse got ill=%0b ev=%0b op=%b dst=%0b src=%0b required 1 1 00000 0 0",
               illegal[0], ex_valid[0], ex_aluop[0], ex_regdst[0], ex_alusrc[0]);
    end
    tick();
    checks++;
    if (illegal[0] !== 1'b0) begin failures++; $display("FAIL ill_one_cycle got ill=%0b required 0", illegal[0]); end
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_memwrite[0] || wb_regwrite[0]) strobes++;
      tick();
    end
    checks++;
    if (strobes != 0) begin failures++; $display("FAIL ill_no_strobe got %0d required 0", strobes); end
  endtask

  task automatic test_reset_mid();
    sel = 2;
    drive(1'b1, OP_LW, 4'd1, 4'd0, 4'd10);
    tick();
    drive(1'b0, OP_NOP, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    checks++;
    if ({mem_valid[2], id_ready[2]} !== 2'b10) begin
      failures++;
      $display("FAIL rmid_held got mv=%0b rdy=%0b required 1 0", mem_valid[2], id_ready[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid[2], mem_valid[2], wb_valid[2], mem_memwrite[2], wb_regwrite[2], id_ready[2]} !== 6'b000001) begin
      failures++;
      $display("FAIL rmid_async got ev=%0b mv=%0b wv=%0b mw=%0b rw=%0b rdy=%0b required 0 0 0 0 0 1",
               ex_valid[2], mem_valid[2], wb_valid[2], mem_memwrite[2], wb_regwrite[2], id_ready[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd11);
    exp_q.push_back(4'd11);
    checks++;
    if (id_ready[2] !== 1'b1) begin failures++; $display("FAIL rmid_ready got %0b required 1", id_ready[2]); end
    tick();
    drain(5);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_drain pending=%0d required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 0;
    rst_n     = 1'b0;
    ex_zero   = 1'b0;
    id_valid  = 1'b0;
    id_opcode = 4'h0;
    id_rs     = 4'h0;
    id_rt     = 4'h0;
    id_rd     = 4'h0;
    test_reset();
    test_alu_chain();
    test_decode();
    test_load_use();
    test_mem_hold();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
